spi_master_core: RTL and testbench

SPI shift engine directly downstream of the FIFO-to-SPI request decoder. It starts on the single-cycle start pulse, takes words from the TX FIFO and serialises them onto MOSI under the Control and Transfer Control register settings. It deserialises MISO into the RX FIFO and drives the slave selects. At the end it returns a one-cycle done pulse that clears the decoder's busy flag.

---
 rtl/spi_master_core.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_master_core.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// SPI shift engine: pulls words from the TX FIFO, shifts them out on MOSI,
// assembles MISO into RX words, drives one slave select and pulses done.
//
// state | meaning
// IDLE  | waiting for an accepted start; SCLK follows live CPOL, SS released
// SETUP | select asserted, one half period before the first word
// LOAD  | waiting for a TX word; pops it and primes the bit counter
// SHIFT | generating WLEN+1 SCLK pulses, moving MOSI and sampling MISO
// STORE | waiting for RX space; pushes the received word
// HOLD  | select held one half period after the last word
// DONE  | one-cycle completion pulse
module spi_master_core #(
    parameter int SS_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [31:0]         reg_control_i,
    input  logic [31:0]         reg_trans_ctrl_i,
    input  logic                trans_start_i,
    output logic                trans_done_o,
    input  logic                tx_empty_i,
    input  logic [31:0]         tx_data_i,
    output logic                tx_pull_o,
    input  logic                rx_full_i,
    output logic [31:0]         rx_data_o,
    output logic                rx_push_o,
    output logic                sclk_o,
    output logic                mosi_o,
    input  logic                miso_i,
    output logic [SS_WIDTH-1:0] ss_n_o
);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD, SHIFT, STORE, HOLD, DONE
    } state_t;

    state_t              state, state_n;
    logic [7:0]          cnt, cnt_n;
    logic [4:0]          bit_cnt, bit_cnt_n;
    logic [7:0]          word_cnt, word_cnt_n;
    logic [7:0]          div, div_n;
    logic                cpol, cpol_n;
    logic                cpha, cpha_n;
    logic                lsb, lsb_n;
    logic [4:0]          wlen, wlen_n;
    logic [31:0]         tx_word, tx_word_n;
    logic [31:0]         rx_shift, rx_shift_n;
    logic [31:0]         rx_data, rx_data_n;
    logic                sclk, sclk_n;
    logic                mosi, mosi_n;
    logic [SS_WIDTH-1:0] ss_n, ss_n_n;
    logic [4:0]          cur_idx, nxt_idx, first_idx;
    logic                unused_bits;

    // Status, start-edge and reserved register bits are not used by the shifter.
    assign unused_bits = ^{reg_control_i[31:12], reg_trans_ctrl_i[31:17], reg_trans_ctrl_i[13]};

    // Bit position in the word for the current/next bit; the bit counter always
    // counts down from WLEN, LSB-first simply mirrors the position.
    assign cur_idx   = lsb ? (wlen - bit_cnt) : bit_cnt;
    assign nxt_idx   = lsb ? (wlen - bit_cnt + 5'd1) : (bit_cnt - 5'd1);
    assign first_idx = lsb ? 5'd0 : wlen;

    assign rx_data_o = rx_data;
    assign sclk_o    = sclk;
    assign mosi_o    = mosi;
    assign ss_n_o    = ss_n;

    // Out-of-range select index leaves every select released.
    function automatic logic [SS_WIDTH-1:0] ss_decode(input logic [2:0] idx);
        logic [SS_WIDTH-1:0] v;
        v = '1;
        for (int i = 0; i < SS_WIDTH; i++) begin
            if (int'(idx) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            div      <= '0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            lsb      <= 1'b0;
            wlen     <= '0;
            tx_word  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_cnt_n;
            word_cnt <= word_cnt_n;
            div      <= div_n;
            cpol     <= cpol_n;
            cpha     <= cpha_n;
            lsb      <= lsb_n;
            wlen     <= wlen_n;
            tx_word  <= tx_word_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            sclk     <= sclk_n;
            mosi     <= mosi_n;
            ss_n     <= ss_n_n;
        end
    end

    // Next-state, datapath updates and FIFO/done strobes.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_cnt_n  = bit_cnt;
        word_cnt_n = word_cnt;
        div_n      = div;
        cpol_n     = cpol;
        cpha_n     = cpha;
        lsb_n      = lsb;
        wlen_n     = wlen;
        tx_word_n  = tx_word;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        sclk_n     = sclk;
        mosi_n     = mosi;
        ss_n_n     = ss_n;
        tx_pull_o    = 1'b0;
        rx_push_o    = 1'b0;
        trans_done_o = 1'b0;
        case (state)
            IDLE: begin
                sclk_n = reg_control_i[8];
                mosi_n = 1'b0;
                ss_n_n = '1;
                if (trans_start_i && reg_control_i[11]) begin
                    div_n      = reg_control_i[7:0];
                    cpol_n     = reg_control_i[8];
                    cpha_n     = reg_control_i[9];
                    lsb_n      = reg_control_i[10];
                    wlen_n     = reg_trans_ctrl_i[4:0];
                    word_cnt_n = reg_trans_ctrl_i[12:5];
                    cnt_n      = reg_control_i[7:0];
                    ss_n_n     = ss_decode(reg_trans_ctrl_i[16:14]);
                    state_n    = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) state_n = LOAD;
                else             cnt_n   = cnt - 8'd1;
            end
            LOAD: begin
                sclk_n = cpol;
                if (!tx_empty_i) begin
                    tx_pull_o  = 1'b1;
                    tx_word_n  = tx_data_i;
                    bit_cnt_n  = wlen;
                    rx_shift_n = '0;
                    cnt_n      = div;
                    if (!cpha) mosi_n = tx_data_i[first_idx];
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    cnt_n  = div;
                    sclk_n = ~sclk;
                    if (sclk == cpol) begin
                        // leading edge
                        if (!cpha) rx_shift_n[cur_idx] = miso_i;
                        else       mosi_n = tx_word[cur_idx];
                    end else begin
                        // trailing edge
                        if (cpha) rx_shift_n[cur_idx] = miso_i;
                        if (bit_cnt == 5'd0) begin
                            rx_data_n = rx_shift_n;
                            state_n   = STORE;
                        end else begin
                            bit_cnt_n = bit_cnt - 5'd1;
                            if (!cpha) mosi_n = tx_word[nxt_idx];
                        end
                    end
                end
            end
            STORE: begin
                if (!rx_full_i) begin
                    rx_push_o = 1'b1;
                    if (word_cnt == 8'd0) begin
                        cnt_n   = div;
                        state_n = HOLD;
                    end else begin
                        word_cnt_n = word_cnt - 8'd1;
                        state_n    = LOAD;
                    end
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    ss_n_n  = '1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            DONE: begin
                trans_done_o = 1'b1;
                state_n      = IDLE;
            end
            default: begin
                ss_n_n  = '1;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: TX FIFO model, RX capture and SCLK/MOSI
// monitors, with one task per scenario.
module tb_spi_master_core;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [31:0] reg_control_i = '0;
    logic [31:0] reg_trans_ctrl_i = '0;
    logic        trans_start_i = 1'b0;
    logic        trans_done_o;
    logic        tx_empty_i = 1'b1;
    logic [31:0] tx_data_i = '0;
    logic        tx_pull_o;
    logic        rx_full_i = 1'b0;
    logic [31:0] rx_data_o;
    logic        rx_push_o;
    logic        sclk_o;
    logic        mosi_o;
    logic        miso_i;
    logic [7:0]  ss_n_o;

    logic        loop_en = 1'b1;
    logic        miso_val = 1'b0;
    assign miso_i = loop_en ? mosi_o : miso_val;

    spi_master_core #(.SS_WIDTH(8)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .reg_control_i(reg_control_i), .reg_trans_ctrl_i(reg_trans_ctrl_i),
        .trans_start_i(trans_start_i), .trans_done_o(trans_done_o),
        .tx_empty_i(tx_empty_i), .tx_data_i(tx_data_i), .tx_pull_o(tx_pull_o),
        .rx_full_i(rx_full_i), .rx_data_o(rx_data_o), .rx_push_o(rx_push_o),
        .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i), .ss_n_o(ss_n_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    int          pull_cnt, push_cnt, done_cnt, lead_cnt, mosi_n, width, wmin, wmax;
    logic [63:0] mosi_log;
    logic        cpol_exp = 1'b0;
    logic        sclk_prev = 1'b0;
    logic        pull_seen = 1'b0;

    task automatic refresh_tx();
        tx_empty_i = (txq.size() == 0);
        tx_data_i  = tx_empty_i ? 32'h0 : txq[0];
    endtask

    // Observation point: mid-cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (tx_pull_o) begin
            pull_cnt++;
            pull_seen = 1'b1;
        end
        if (rx_push_o) begin
            push_cnt++;
            rxq.push_back(rx_data_o);
        end
        if (trans_done_o) done_cnt++;
        if (sclk_o != cpol_exp) begin
            if (sclk_prev == cpol_exp) begin
                lead_cnt++;
                if (mosi_n < 64) mosi_log[mosi_n] = mosi_o;
                mosi_n++;
                width = 1;
            end else begin
                width++;
            end
        end else if (sclk_prev != cpol_exp) begin
            if (width < wmin) wmin = width;
            if (width > wmax) wmax = width;
        end
        sclk_prev = sclk_o;
    end

    // TX FIFO pop lands just after the edge that consumed the head word.
    always @(posedge clk_i) begin
        #1;
        if (pull_seen) begin
            pull_seen = 1'b0;
            if (txq.size() > 0) void'(txq.pop_front());
            refresh_tx();
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        pull_cnt = 0; push_cnt = 0; done_cnt = 0; lead_cnt = 0;
        mosi_n = 0; mosi_log = '0; width = 0; wmin = 1000; wmax = 0;
        rxq.delete();
    endtask

    task automatic set_cfg(input logic [7:0] div, input logic cpol, input logic cpha,
                           input logic lsb, input logic en, input logic [4:0] wlen,
                           input logic [7:0] wcnt, input logic [2:0] ss);
        reg_control_i    = {20'h0, en, lsb, cpha, cpol, div};
        reg_trans_ctrl_i = {15'h0, ss, 1'b0, wcnt, wlen};
        cpol_exp = cpol;
        ticks(3);
        clear_stats();
    endtask

    task automatic push_tx(input logic [31:0] w);
        txq.push_back(w);
        refresh_tx();
    endtask

    task automatic start_pulse();
        trans_start_i = 1'b1;
        tick();
        trans_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_lead(input int target, input int budget, input string name);
        int n = 0;
        while (lead_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (lead_cnt < target) begin
            errors++;
            $display("FAIL %s_sclk_timeout: got %0d pulses, required %0d", name, lead_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        clear_stats();
        ticks(3);
        checks++; if (ss_n_o !== 8'hFF) begin errors++; $display("FAIL reset_ss: got %h required ff", ss_n_o); end
        checks++; if (sclk_o !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b required 0", sclk_o); end
        checks++; if (mosi_o !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b required 0", mosi_o); end
        checks++; if (rx_data_o !== 32'h0) begin errors++; $display("FAIL reset_rx_data: got %h required 0", rx_data_o); end
        checks++; if ({trans_done_o, tx_pull_o, rx_push_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b required 000", {trans_done_o, tx_pull_o, rx_push_o}); end
        reset_n_i = 1'b1;
        ticks(2);
    endtask

    task automatic test_single_byte();
        set_cfg(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 8'd0, 3'd2);
        loop_en = 1'b1;
        push_tx(32'hFFFF_FFA5);
        start_pulse();
        checks++; if (ss_n_o !== 8'hFB) begin errors++; $display("FAIL single_ss: got %h required fb", ss_n_o); end
        wait_done(200, "single");
        // MOSI sequence 1,0,1,0,0,1,0,1 stored first bit at index 0
        checks++; if (mosi_log[7:0] !== 8'b1010_0101) begin errors++; $display("FAIL single_mosi: got %b required 10100101", mosi_log[7:0]); end
        checks++; if (lead_cnt !== 8) begin errors++; $display("FAIL single_pulses: got %0d required 8", lead_cnt); end
        checks++; if (wmin !== 1 || wmax !== 1) begin errors++; $display("FAIL single_high_width: got %0d..%0d required 1", wmin, wmax); end
        checks++; if (push_cnt !== 1) begin errors++; $display("FAIL single_pushes: got %0d required 1", push_cnt); end
        checks++; if ((rxq.size() > 0 ? rxq[0] : 32'hDEAD_BEEF) !== 32'h0000_00A5) begin errors++; $display("FAIL single_rx: got %h required 000000a5", rx_data_o); end
        ticks(5);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", done_cnt); end
        checks++; if (ss_n_o !== 8'hFF) begin errors++; $display("FAIL single_ss_after: got %h required ff", ss_n_o); end
    endtask

    task automatic test_mode3_lsb();
        set_cfg(8'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 8'd0, 3'd0);
        loop_en = 1'b0;
        miso_val = 1'b1;
        checks++; if (sclk_o !== 1'b1) begin errors++; $display("FAIL mode3_idle_sclk: got %b required 1", sclk_o); end
        push_tx(32'h1234_5678);
        start_pulse();
        wait_done(800, "mode3");
        checks++; if (mosi_log[0] !== 1'b0) begin errors++; $display("FAIL mode3_first_bit: got %b required 0", mosi_log[0]); end
        checks++; if (mosi_log[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL mode3_mosi_word: got %h required 12345678", mosi_log[31:0]); end
        checks++; if (lead_cnt !== 32) begin errors++; $display("FAIL mode3_pulses: got %0d required 32", lead_cnt); end
        checks++; if (wmin !== 4 || wmax !== 4) begin errors++; $display("FAIL mode3_half_period: got %0d..%0d required 4", wmin, wmax); end
        checks++; if ((rxq.size() > 0 ? rxq[0] : 32'h0) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mode3_rx: got %h required ffffffff", rx_data_o); end
        loop_en = 1'b1;
        miso_val = 1'b0;
    endtask

    task automatic test_tx_underflow();
        set_cfg(8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 8'd2, 3'd0);
        push_tx(32'h11);
        start_pulse();
        ticks(50);
        checks++; if (ss_n_o !== 8'hFE) begin errors++; $display("FAIL underflow_ss: got %h required fe", ss_n_o); end
        checks++; if (sclk_o !== 1'b0) begin errors++; $display("FAIL underflow_sclk: got %b required 0", sclk_o); end
        checks++; if (lead_cnt !== 8 || pull_cnt !== 1 || push_cnt !== 1) begin errors++; $display("FAIL underflow_stall: got pulses %0d pulls %0d pushes %0d required 8 1 1", lead_cnt, pull_cnt, push_cnt); end
        push_tx(32'h22);
        push_tx(32'h33);
        wait_done(400, "underflow");
        checks++; if (pull_cnt !== 3 || push_cnt !== 3) begin errors++; $display("FAIL underflow_counts: got pulls %0d pushes %0d required 3 3", pull_cnt, push_cnt); end
        checks++; if (lead_cnt !== 24) begin errors++; $display("FAIL underflow_pulses: got %0d required 24", lead_cnt); end
        checks++; if (rxq.size() !== 3 || rxq[1] !== 32'h22 || rxq[2] !== 32'h33) begin errors++; $display("FAIL underflow_rx: got %0d words required 11 22 33", rxq.size()); end
    endtask

    task automatic test_rx_backpressure();
        set_cfg(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 8'd1, 3'd1);
        push_tx(32'h81);
        push_tx(32'h7E);
        rx_full_i = 1'b1;
        start_pulse();
        wait_lead(8, 100, "backpressure");
        ticks(20);
        checks++; if (push_cnt !== 0) begin errors++; $display("FAIL bp_no_push: got %0d required 0", push_cnt); end
        checks++; if (lead_cnt !== 8 || sclk_o !== 1'b0) begin errors++; $display("FAIL bp_sclk_idle: got pulses %0d sclk %b required 8 0", lead_cnt, sclk_o); end
        rx_full_i = 1'b0;
        #1;
        checks++; if (rx_push_o !== 1'b1) begin errors++; $display("FAIL bp_push_release: got %b required 1", rx_push_o); end
        checks++; if (rx_data_o !== 32'h81) begin errors++; $display("FAIL bp_rx_held: got %h required 00000081", rx_data_o); end
        wait_done(200, "backpressure");
        checks++; if (push_cnt !== 2 || (rxq.size() > 1 ? rxq[1] : 32'h0) !== 32'h7E) begin errors++; $display("FAIL bp_second_word: got pushes %0d required 2 with 7e", push_cnt); end
    endtask

    task automatic test_start_gating();
        set_cfg(8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 8'd0, 3'd3);
        push_tx(32'h55);
        start_pulse();
        ticks(30);
        checks++; if (pull_cnt !== 0 || done_cnt !== 0 || lead_cnt !== 0 || ss_n_o !== 8'hFF) begin errors++; $display("FAIL gate_en0: got pulls %0d done %0d pulses %0d ss %h required 0 0 0 ff", pull_cnt, done_cnt, lead_cnt, ss_n_o); end
        set_cfg(8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 8'd0, 3'd3);
        start_pulse();
        ticks(10);
        start_pulse();
        wait_done(200, "gate");
        ticks(40);
        checks++; if (done_cnt !== 1 || pull_cnt !== 1) begin errors++; $display("FAIL gate_second_start: got done %0d pulls %0d required 1 1", done_cnt, pull_cnt); end
        checks++; if (ss_n_o !== 8'hFF) begin errors++; $display("FAIL gate_idle_ss: got %h required ff", ss_n_o); end
        checks++; if ((rxq.size() > 0 ? rxq[0] : 32'h0) !== 32'h55) begin errors++; $display("FAIL gate_rx: got %h required 00000055", rx_data_o); end
    endtask

    task automatic test_reset_mid_word();
        set_cfg(8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 8'd0, 3'd4);
        push_tx(32'hC3);
        start_pulse();
        wait_lead(3, 100, "midreset");
        reset_n_i = 1'b0;
        #1;
        checks++; if (ss_n_o !== 8'hFF || sclk_o !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got ss %h sclk %b required ff 0", ss_n_o, sclk_o); end
        ticks(3);
        checks++; if (push_cnt !== 0 || done_cnt !== 0) begin errors++; $display("FAIL midreset_no_push: got pushes %0d done %0d required 0 0", push_cnt, done_cnt); end
        reset_n_i = 1'b1;
        ticks(2);
        clear_stats();
        push_tx(32'h3C);
        start_pulse();
        wait_done(200, "postreset");
        checks++; if (push_cnt !== 1 || (rxq.size() > 0 ? rxq[0] : 32'h0) !== 32'h3C) begin errors++; $display("FAIL postreset_rx: got pushes %0d data %h required 1 0000003c", push_cnt, rx_data_o); end
        checks++; if (lead_cnt !== 8) begin errors++; $display("FAIL postreset_pulses: got %0d required 8", lead_cnt); end
    endtask

    initial begin
        clear_stats();
        refresh_tx();
        test_reset();
        test_single_byte();
        test_mode3_lsb();
        test_tx_underflow();
        test_rx_backpressure();
        test_start_gating();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
